// File: rtl/dice_roll_arbiter.sv
// Round-robin arbiter that shares one dice roller among four requesters,
// sequences the roll pulses, and returns a range-checked, saturating sum.
module dice_roll_arbiter #(
  parameter int ROLL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [7:0]  die_sel,
  input  logic [11:0] num_dice,
  output logic [3:0]  gnt,
  output logic        busy,
  output logic        done,
  output logic [1:0]  done_id,
  output logic [7:0]  sum,
  output logic        err,
  output logic        roll_o,
  output logic [1:0]  die_select_o,
  input  logic [7:0]  rolled_number
);

  localparam int DATA_W = 8;
  localparam int WC_W   = $clog2(ROLL_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_ROLL, S_WAIT, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [1:0]        rr_ptr;
  logic              win_vld;
  logic [1:0]        win_idx;
  logic [1:0]        sel_die;
  logic [2:0]        sel_num;
  logic [1:0]        winner;
  logic [2:0]        remaining;
  logic [WC_W-1:0]   wcnt;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_nxt;
  logic              err_flag;
  logic              err_nxt;
  logic              last_wait;
  logic              finish;

  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_W] ? {DATA_W{1'b1}} : s[DATA_W-1:0];
  endfunction

  function automatic logic out_of_range(input logic [1:0] die, input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] faces;
    case (die)
      2'b00:   faces = 8'd4;
      2'b01:   faces = 8'd6;
      2'b10:   faces = 8'd8;
      default: faces = 8'd20;
    endcase
    return (v == 8'd0) || (v > faces);
  endfunction

  // Search begins one past the last winner so every held request is served in turn.
  always_comb begin
    win_vld = 1'b0;
    win_idx = rr_ptr;
    for (int i = 1; i <= 4; i++) begin
      if (!win_vld && req[rr_ptr + 2'(i)]) begin
        win_vld = 1'b1;
        win_idx = rr_ptr + 2'(i);
      end
    end
    sel_die = die_sel[{win_idx, 1'b0} +: 2];
    sel_num = num_dice[4'(win_idx) * 4'd3 +: 3];
  end

  assign last_wait = (state == S_WAIT) && (wcnt == WC_W'(1));
  assign finish    = last_wait && (remaining == 3'd0);
  assign acc_nxt   = sat_add(acc, rolled_number);
  assign err_nxt   = err_flag | out_of_range(die_select_o, rolled_number);

  always_comb begin
    state_nxt = state;
    roll_o    = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: if (win_vld) state_nxt = S_ROLL;
      S_ROLL: begin
        roll_o    = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: if (wcnt == WC_W'(1)) state_nxt = (remaining == 3'd0) ? S_DONE : S_ROLL;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control and reported results: cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      gnt          <= 4'b0000;
      rr_ptr       <= 2'd3;
      done         <= 1'b0;
      done_id      <= 2'd0;
      sum          <= '0;
      err          <= 1'b0;
      die_select_o <= 2'b00;
    end else begin
      state <= state_nxt;
      done  <= finish;
      if (state == S_IDLE && win_vld) begin
        gnt          <= 4'b0001 << win_idx;
        die_select_o <= sel_die;
      end
      if (state == S_DONE) begin
        gnt    <= 4'b0000;
        rr_ptr <= winner;
      end
      if (finish) begin
        sum     <= acc_nxt;
        err     <= err_nxt;
        done_id <= winner;
      end
    end
  end

  // Per-operation working registers: always initialised at grant before use.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && win_vld) begin
      winner    <= win_idx;
      remaining <= sel_num;
      acc       <= '0;
      err_flag  <= 1'b0;
    end
    if (state == S_ROLL)
      wcnt <= WC_W'(ROLL_LATENCY);
    else if (state == S_WAIT)
      wcnt <= wcnt - WC_W'(1);
    if (last_wait) begin
      acc      <= acc_nxt;
      err_flag <= err_nxt;
      if (remaining != 3'd0) remaining <= remaining - 3'd1;
    end
  end

endmodule

// File: tb/tb_dice_roll_arbiter.sv
// Bench for dice_roll_arbiter: mock registered roller, negedge monitor and
// per-scenario tasks checked against a behavioural model of the rules.
module tb_dice_roll_arbiter;
  localparam int L = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0;
  logic [7:0]  die_sel = '0;
  logic [11:0] num_dice = '0;
  logic [3:0]  gnt;
  logic        busy, done, err, roll_o;
  logic [1:0]  done_id, die_select_o;
  logic [7:0]  sum;
  logic [7:0]  rolled_number = '0;

  dice_roll_arbiter #(.ROLL_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .req(req), .die_sel(die_sel), .num_dice(num_dice),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .sum(sum), .err(err),
    .roll_o(roll_o), .die_select_o(die_select_o), .rolled_number(rolled_number)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  int unsigned vq[$];
  int unsigned given[$];
  logic [1:0]  cur_die = 2'b11;

  function automatic int faces(input logic [1:0] d);
    case (d)
      2'b00:   return 4;
      2'b01:   return 6;
      2'b10:   return 8;
      default: return 20;
    endcase
  endfunction

  function automatic int unsigned rand_val(input logic [1:0] d);
    int f;
    f = faces(d);
    if ($urandom_range(0, 7) == 0)
      return ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(f + 1, 255);
    return $urandom_range(1, f);
  endfunction

  function automatic int unsigned next_val();
    int unsigned v;
    if (vq.size() > 0) v = vq.pop_front();
    else v = rand_val(cur_die);
    given.push_back(v);
    return v;
  endfunction

  // Mock roller with one cycle of latency from the roll sample edge.
  always @(posedge clk) if (roll_o) rolled_number <= 8'(next_val());

  int         roll_cyc[$];
  logic [1:0] roll_die[$];
  int         done_cyc[$];
  logic [1:0] done_idq[$];
  logic [7:0] done_sum[$];
  logic       done_err[$];
  logic [3:0] done_gnt[$];
  int         gnt_bad = 0;

  always @(negedge clk) begin
    if (roll_o) begin
      roll_cyc.push_back(cyc);
      roll_die.push_back(die_select_o);
    end
    if (done) begin
      done_cyc.push_back(cyc);
      done_idq.push_back(done_id);
      done_sum.push_back(sum);
      done_err.push_back(err);
      done_gnt.push_back(gnt);
    end
    if ((gnt & (gnt - 4'd1)) != 4'd0 || (busy && gnt == 4'd0)) gnt_bad++;
  end

  function automatic int model_sum();
    int s = 0;
    foreach (given[k]) s += given[k];
    return (s > 255) ? 255 : s;
  endfunction

  function automatic logic model_err(input logic [1:0] d);
    logic e = 1'b0;
    foreach (given[k]) if (given[k] == 0 || given[k] > faces(d)) e = 1'b1;
    return e;
  endfunction

  function automatic int roll_errs(input int c0, input int n);
    int e = 0;
    if (roll_cyc.size() != n) e++;
    foreach (roll_cyc[k]) if (roll_cyc[k] != c0 + 1 + k * (1 + L)) e++;
    return e;
  endfunction

  function automatic int die_errs(input logic [1:0] d);
    int e = 0;
    foreach (roll_die[k]) if (roll_die[k] !== d) e++;
    return e;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    roll_cyc.delete(); roll_die.delete(); done_cyc.delete(); done_idq.delete();
    done_sum.delete(); done_err.delete(); done_gnt.delete(); given.delete();
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (!busy) begin ok = 1'b1; return; end
      step();
    end
  endtask

  task automatic do_op(input int r, input logic [1:0] die, input logic [2:0] nd,
                       input bit disturb, output int c0, output bit ok);
    wait_idle(ok);
    c0 = cyc;
    if (!ok) return;
    clear_mon();
    cur_die = die;
    die_sel = 8'($urandom);
    num_dice = 12'($urandom);
    die_sel[2*r +: 2] = die;
    num_dice[3*r +: 3] = nd;
    req = 4'b0001 << r;
    c0 = cyc;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      step();
      if (disturb && cyc == c0 + 3) begin
        req = 4'b0000;
        die_sel = ~die_sel;
        num_dice = ~num_dice;
      end
      if (done_cyc.size() > 0) begin ok = 1'b1; break; end
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; die_sel = '0; num_dice = '0;
    step(); step();
    total++;
    if ({gnt, busy, done, roll_o} !== 7'd0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=0", {gnt, busy, done, roll_o});
    end
    total++;
    if ({sum, err, done_id, die_select_o} !== 13'd0) begin
      bad++; $display("FAIL reset_data got=%h want=0", {sum, err, done_id, die_select_o});
    end
    reset = 1'b0;
    clear_mon();
    repeat (4) step();
    total++;
    if (roll_cyc.size() != 0 || done_cyc.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL idle_quiet got rolls=%0d dones=%0d busy=%b want 0 0 0",
                      roll_cyc.size(), done_cyc.size(), busy);
    end
  endtask

  task automatic test_single();
    int c0; bit ok;
    vq.delete(); vq.push_back(5);
    do_op(0, 2'b01, 3'd0, 1'b0, c0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_timeout got=no_done want=done"); return; end
    total++;
    if (roll_cyc.size() != 1 || roll_cyc[0] != c0 + 1) begin
      bad++; $display("FAIL single_roll got=%0d rolls want=1 at cycle %0d", roll_cyc.size(), c0 + 1);
    end
    total++;
    if (done_cyc.size() != 1 || done_cyc[0] != c0 + 3) begin
      bad++; $display("FAIL single_done_cycle got=%0d want=%0d", done_cyc[0] - c0, 3);
    end
    total++;
    if ({done_sum[0], done_err[0], done_idq[0], done_gnt[0]} !== {8'd5, 1'b0, 2'd0, 4'b0001}) begin
      bad++; $display("FAIL single_result got sum=%0d err=%b id=%0d gnt=%b want 5 0 0 0001",
                      done_sum[0], done_err[0], done_idq[0], done_gnt[0]);
    end
  endtask

  task automatic test_multi();
    int c0; bit ok;
    vq.delete(); repeat (8) vq.push_back(20);
    do_op(2, 2'b11, 3'd7, 1'b0, c0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL multi_timeout got=no_done want=done"); return; end
    total++;
    if (roll_errs(c0, 8) != 0) begin
      bad++; $display("FAIL multi_rolls got=%0d rolls (%0d timing errs) want=8", roll_cyc.size(), roll_errs(c0, 8));
    end
    total++;
    if (die_errs(2'b11) != 0) begin
      bad++; $display("FAIL multi_die got=%0d mismatches want=0", die_errs(2'b11));
    end
    total++;
    if ({done_sum[0], done_err[0], done_idq[0]} !== {8'd160, 1'b0, 2'd2} || done_cyc[0] != c0 + 17) begin
      bad++; $display("FAIL multi_result got sum=%0d err=%b id=%0d at=%0d want 160 0 2 17",
                      done_sum[0], done_err[0], done_idq[0], done_cyc[0] - c0);
    end
  endtask

  task automatic test_round_robin();
    int e = 0;
    bit ok = 1'b0;
    reset = 1'b1; req = '0;
    step(); step();
    reset = 1'b0;
    clear_mon(); vq.delete();
    cur_die = 2'b11; die_sel = 8'hFF; num_dice = '0;
    req = 4'b1111;
    for (int n = 0; n < 100; n++) begin
      step();
      if (done_cyc.size() >= 5) begin ok = 1'b1; break; end
    end
    req = 4'b0000;
    total++;
    if (!ok) begin bad++; $display("FAIL rr_timeout got=%0d dones want=5", done_cyc.size()); return; end
    for (int k = 0; k < 5; k++) begin
      if (done_idq[k] !== 2'(k % 4)) e++;
      if (int'(done_sum[k]) != ((given[k] > 255) ? 255 : given[k])) e++;
      if (done_err[k] !== (given[k] == 0 || given[k] > 20)) e++;
      if (k > 0 && done_cyc[k] - done_cyc[k-1] != 4) e++;
    end
    total++;
    if (e != 0) begin
      bad++; $display("FAIL rr_sequence got ids=%0d%0d%0d%0d%0d (%0d errs) want=01230",
                      done_idq[0], done_idq[1], done_idq[2], done_idq[3], done_idq[4], e);
    end
    total++;
    if (gnt_bad != 0) begin bad++; $display("FAIL gnt_onehot got=%0d bad cycles want=0", gnt_bad); end
  endtask

  task automatic test_error_sat();
    int c0; bit ok;
    int r; logic [1:0] d; logic [2:0] nd; int xs; logic xe;
    for (int t = 0; t < 5; t++) begin
      vq.delete();
      case (t)
        0: begin r = 1; d = 2'b00; nd = 3'd1; vq.push_back(0); vq.push_back(7); xs = 7; xe = 1'b1; end
        1: begin r = 3; d = 2'(t + $urandom_range(0, 2)); nd = 3'd7; repeat (8) vq.push_back(200); xs = 255; xe = 1'b1; end
        2: begin r = 0; d = 2'b01; nd = 3'd1; vq.push_back(6); vq.push_back(7); xs = 13; xe = 1'b1; end
        3: begin r = 2; d = 2'b10; nd = 3'd1; vq.push_back(8); vq.push_back(1); xs = 9; xe = 1'b0; end
        default: begin r = 1; d = 2'b00; nd = 3'd0; vq.push_back(4); xs = 4; xe = 1'b0; end
      endcase
      do_op(r, d, nd, 1'b0, c0, ok);
      total++;
      if (!ok) begin
        bad++; $display("FAIL errsat%0d_timeout got=no_done want=done", t);
      end else if (int'(done_sum[0]) != xs || done_err[0] !== xe) begin
        bad++; $display("FAIL errsat%0d got sum=%0d err=%b want sum=%0d err=%b", t, done_sum[0], done_err[0], xs, xe);
      end
    end
    repeat (3) step();
    total++;
    if (sum !== 8'd4 || err !== 1'b0 || done_id !== 2'd1) begin
      bad++; $display("FAIL result_hold got sum=%0d err=%b id=%0d want 4 0 1", sum, err, done_id);
    end
  endtask

  task automatic test_disturb();
    int c0; bit ok; int xs = 0;
    vq.delete();
    for (int k = 0; k < 4; k++) begin
      vq.push_back($urandom_range(1, 8));
      xs += vq[k];
    end
    do_op(0, 2'b10, 3'd3, 1'b1, c0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL disturb_timeout got=no_done want=done"); return; end
    total++;
    if (roll_errs(c0, 4) != 0 || die_errs(2'b10) != 0) begin
      bad++; $display("FAIL disturb_rolls got=%0d rolls want=4 with die 2", roll_cyc.size());
    end
    total++;
    if (int'(done_sum[0]) != xs || done_err[0] !== 1'b0 || done_idq[0] !== 2'd0 || done_cyc[0] != c0 + 9) begin
      bad++; $display("FAIL disturb_result got sum=%0d err=%b id=%0d at=%0d want %0d 0 0 9",
                      done_sum[0], done_err[0], done_idq[0], done_cyc[0] - c0, xs);
    end
  endtask

  task automatic test_reset_mid();
    int c0; bit ok;
    wait_idle(ok);
    clear_mon(); vq.delete(); cur_die = 2'b01;
    die_sel = 8'h55; num_dice = 12'hFFF;
    req = 4'b0100;
    c0 = cyc;
    step(); step();
    total++;
    if (busy !== 1'b1 || gnt !== 4'b0100) begin
      bad++; $display("FAIL abort_setup got busy=%b gnt=%b want 1 0100", busy, gnt);
    end
    reset = 1'b1; req = 4'b0000;
    step();
    total++;
    if ({busy, roll_o, done, gnt} !== 7'd0) begin
      bad++; $display("FAIL abort_idle got=%b want=0 at cycle %0d", {busy, roll_o, done, gnt}, cyc - c0);
    end
    reset = 1'b0;
    repeat (6) step();
    total++;
    if (done_cyc.size() != 0) begin bad++; $display("FAIL abort_no_done got=%0d dones want=0", done_cyc.size()); end
    clear_mon();
    num_dice = 12'd0;
    req = 4'b0011;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      step();
      if (done_cyc.size() > 0) begin ok = 1'b1; break; end
    end
    req = 4'b0000;
    total++;
    if (!ok || done_idq[0] !== 2'd0) begin
      bad++; $display("FAIL abort_rr_restart got id=%0d ok=%b want 0", done_idq[0], ok);
    end
  endtask

  task automatic test_random();
    int c0; bit ok; int r; logic [1:0] d; logic [2:0] nd; int e;
    vq.delete();
    for (int t = 0; t < 25; t++) begin
      r = $urandom_range(0, 3); d = 2'($urandom); nd = 3'($urandom);
      do_op(r, d, nd, 1'b0, c0, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rand%0d_timeout got=no_done want=done", t); continue; end
      e = roll_errs(c0, int'(nd) + 1) + die_errs(d);
      if (done_cyc.size() != 1 || done_cyc[0] != c0 + 1 + (int'(nd) + 1) * (1 + L)) e++;
      if (done_idq[0] !== 2'(r) || done_gnt[0] !== (4'b0001 << r)) e++;
      total++;
      if (e != 0) begin
        bad++; $display("FAIL rand%0d_timing got=%0d errs (rolls=%0d id=%0d) want=0", t, e, roll_cyc.size(), done_idq[0]);
      end
      total++;
      if (int'(done_sum[0]) != model_sum() || done_err[0] !== model_err(d)) begin
        bad++; $display("FAIL rand%0d_result got sum=%0d err=%b want sum=%0d err=%b",
                        t, done_sum[0], done_err[0], model_sum(), model_err(d));
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_round_robin();
    test_error_sat();
    test_disturb();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
